// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    localparam int unsigned DATA_BITS  = 8;
    localparam logic        IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter 0..DIV-1 with synchronous clear; flags the mid-bit and last cycle.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic mid_tick,
    output logic full_tick
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign mid_tick  = (cnt_q == CW'(DIV / 2 - 1));
    assign full_tick = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || full_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// Oversampling UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing.
// rst is asynchronous and active low.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 100_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rxdw,
    output logic       rxrdy,
    output logic       ferr,
    output logic       busy
);

    localparam int unsigned DIV = CLK_HZ / BAUD;
    localparam int unsigned IW  = $clog2(DATA_BITS);

    uart_state_e state_q, state_d;

    logic rx_meta_q, rx_meta_d;
    logic rx_s_q, rx_s_d;
    logic rx_prev_q, rx_prev_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0] rxdw_q, rxdw_d;
    logic rxrdy_q, rxrdy_d;
    logic ferr_q, ferr_d;
    logic baud_clr;
    logic mid_tick;
    logic full_tick;

`ifdef UART_RX_PARITY_EN
    logic parity_bad;
    assign parity_bad = ^{shift_q, rx_s_q};
`endif

    uart_baud_cnt #(.DIV(DIV)) u_baud (
        .clk       (clk),
        .rst_n     (rst),
        .clr       (baud_clr),
        .mid_tick  (mid_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Stop bit is judged at its middle, so IDLE is re-entered half a bit early.
    always_comb begin
        state_d  = state_q;
        baud_clr = 1'b0;
        case (state_q)
            IDLE: begin
                baud_clr = 1'b1;
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (mid_tick) begin
                    baud_clr = 1'b1;
                    state_d  = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (full_tick && (idx_q == IW'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick) begin
                    if (parity_bad) begin
                        state_d = rx_s_q ? IDLE : BREAK;
                    end else begin
                        state_d = STOP;
                    end
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    state_d = rx_s_q ? IDLE : BREAK;
                end
            end
            BREAK: begin
                baud_clr = 1'b1;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        shift_d   = shift_q;
        idx_d     = idx_q;
        rxdw_d    = rxdw_q;
        rxrdy_d   = 1'b0;
        ferr_d    = 1'b0;
        busy      = (state_q != IDLE);
        case (state_q)
            START: begin
                idx_d = '0;
            end
            DATA: begin
                if (full_tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + IW'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (full_tick && parity_bad) begin
                    ferr_d = 1'b1;
                end
            end
`endif
            STOP: begin
                if (full_tick) begin
                    if (rx_s_q) begin
                        rxdw_d  = shift_q;
                        rxrdy_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= IDLE_LEVEL;
            rx_s_q    <= IDLE_LEVEL;
            rx_prev_q <= IDLE_LEVEL;
            shift_q   <= '0;
            idx_q     <= '0;
            rxdw_q    <= 8'h00;
            rxrdy_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            rxdw_q    <= rxdw_d;
            rxrdy_q   <= rxrdy_d;
            ferr_q    <= ferr_d;
        end
    end

    assign rxdw  = rxdw_q;
    assign rxrdy = rxrdy_q;
    assign ferr  = ferr_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed plus randomized frames against an event-level reference of the receiver.
module tb_uart_rx_byte;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int DIV = CLK_HZ / BAUD;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int LAT = 2 + DIV / 2 + 9 * DIV + 1 + (PAR ? DIV : 0);

    typedef struct {
        logic [1:0] kind;   // {rxrdy, ferr}
        logic [7:0] data;
        int         cyc;
    } evt_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] rxdw;
    logic       rxrdy;
    logic       ferr;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic [7:0] last_good = 8'h00;
    evt_t got_q[$];
    evt_t exp_q[$];

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk   (clk),
        .rst   (rst),
        .rx    (rx),
        .rxdw  (rxdw),
        .rxrdy (rxrdy),
        .ferr  (ferr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1 && (rxrdy !== 1'b0 || ferr !== 1'b0)) begin
            evt_t e;
            e.kind = {rxrdy, ferr};
            e.data = rxdw;
            e.cyc  = cyc;
            got_q.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * DIV) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge and records what the receiver must report.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pflip);
        evt_t e;
        int   fall;
        fall = cyc;
        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (DIV) @(negedge clk);
        end
        if (PAR) begin
            rx = (^b) ^ pflip;
            repeat (DIV) @(negedge clk);
        end
        rx = stop_bit;
        repeat (DIV) @(negedge clk);
        if (PAR && pflip) begin
            e.kind = 2'b01; e.data = last_good; e.cyc = fall + LAT - DIV;
        end else if (stop_bit) begin
            e.kind = 2'b10; e.data = b; e.cyc = fall + LAT;
            last_good = b;
        end else begin
            e.kind = 2'b01; e.data = last_good; e.cyc = fall + LAT;
        end
        exp_q.push_back(e);
        if (!stop_bit) idle_bits(1);
    endtask

    task automatic compare_events(input string tag);
        int n;
        repeat (3 * DIV) @(negedge clk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, got_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            check({tag, "_cycle"}, got_q[i].cyc, exp_q[i].cyc);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_rxdw", rxdw, 8'h00);
        check("reset_rxrdy", rxrdy, 1'b0);
        check("reset_ferr", ferr, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;
        idle_bits(1);

        send_frame(8'hF0, 1'b1, 1'b0);
        compare_events("single_f0");
        check("single_f0_rxdw", rxdw, 8'hF0);

        send_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'hA5, 1'b1, 1'b0);
        compare_events("b2b");
        check("b2b_rxdw", rxdw, 8'hA5);

        send_frame(8'h55, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        compare_events("framing");
        check("framing_rxdw", rxdw, 8'h3C);

        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("glitch_busy_hi", busy, 1'b1);
        idle_bits(1);
        check("glitch_busy_lo", busy, 1'b0);
        compare_events("glitch");

        rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            rx = (8'hC3 >> i) & 8'h01;
            repeat (i == 4 ? DIV / 2 : DIV) @(negedge clk);
        end
        rst = 1'b0;
        rx  = 1'b1;
        @(negedge clk);
        check("midrst_rxdw", rxdw, 8'h00);
        check("midrst_rxrdy", rxrdy, 1'b0);
        check("midrst_ferr", ferr, 1'b0);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        last_good = 8'h00;
        got_q.delete();
        exp_q.delete();
        idle_bits(2);
        check("midrst_busy_after", busy, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        compare_events("midrst");
        check("midrst_rxdw_after", rxdw, 8'h81);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        compare_events("parity");
        check("parity_rxdw", rxdw, 8'h07);
`endif

        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            logic       stop_bit;
            logic       pflip;
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 5) != 0);
            pflip    = PAR && ($urandom_range(0, 5) == 0);
            idle_bits($urandom_range(0, 2));
            send_frame(b, stop_bit, pflip);
        end
        compare_events("random");
        check("random_rxdw", rxdw, last_good);
        check("random_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
